// File: rtl/enemy_dir_arbiter.sv
// Round-robin arbiter sharing one 8-bit LFSR direction/duration source among N_ENEMY requesters.
// Optional feature: define ENEMY_CHASE_EN to steer some grants toward the hero.
module enemy_dir_arbiter #(
  parameter int unsigned N_ENEMY = 4,
  parameter int unsigned IDX_W   = 2,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int unsigned MIN_DUR = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ENEMY-1:0]     req,
  input  logic [11:0]            hero_x_pos,
  input  logic [11:0]            hero_y_pos,
  input  logic [N_ENEMY*12-1:0]  enemy_x_pos,
  input  logic [N_ENEMY*12-1:0]  enemy_y_pos,
  output logic [N_ENEMY-1:0]     grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [2:0]             dir,
  output logic [7:0]             dur,
  output logic                   busy,
  output logic [15:0]            grant_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_ENEMY-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         dir_q, dir_d;
  logic [7:0]         dur_q, dur_d;
  logic               busy_q, busy_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     sum;
  logic [2:0]         rnd_dir, sel_dir;
  logic [7:0]         rnd_dur, sel_dur;

  // First requester at or after ptr, wrapping at N_ENEMY (which need not be a power of two).
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_ENEMY)) sum = sum - (IDX_W+1)'(N_ENEMY);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found    = 1'b1;
        pick_idx = sum[IDX_W-1:0];
      end
    end
  end

  assign rnd_dir = (lfsr_q[2:0] >= 3'd5) ? lfsr_q[2:0] - 3'd5 : lfsr_q[2:0];
  assign rnd_dur = 8'(MIN_DUR) + {3'b000, lfsr_q[7:3]};

`ifdef ENEMY_CHASE_EN
  logic [11:0]        ex, ey;
  logic signed [12:0] dx, dy;
  logic [12:0]        adx, ady;
  logic [2:0]         chase_dir;

  always_comb begin
    ex = '0;
    ey = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        ex = enemy_x_pos[12*i +: 12];
        ey = enemy_y_pos[12*i +: 12];
      end
    end
    dx  = $signed({1'b0, hero_x_pos}) - $signed({1'b0, ex});
    dy  = $signed({1'b0, hero_y_pos}) - $signed({1'b0, ey});
    adx = dx[12] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[12] ? $unsigned(-dy) : $unsigned(dy);
    if (adx >= ady && dx != 13'sd0) chase_dir = dx[12] ? 3'd1 : 3'd2;
    else if (dy != 13'sd0)          chase_dir = dy[12] ? 3'd0 : 3'd3;
    else                            chase_dir = 3'd4;
  end

  assign sel_dir = (lfsr_q[7:6] == 2'b11) ? chase_dir : rnd_dir;
  assign sel_dur = (lfsr_q[7:6] == 2'b11) ? 8'(MIN_DUR) : rnd_dur;
`else
  logic unused_pos;
  assign unused_pos = ^{hero_x_pos, hero_y_pos, enemy_x_pos, enemy_y_pos};
  assign sel_dir    = rnd_dir;
  assign sel_dur    = rnd_dur;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dur_d   = dur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = {{(N_ENEMY-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          dir_d   = sel_dir;
          dur_d   = sel_dur;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ptr_d   = (idx_q == IDX_W'(N_ENEMY-1)) ? '0 : idx_q + 1'b1;
        cnt_d   = cnt_q + 16'd1;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      dir_q   <= 3'd4;
      dur_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      dur_q   <= dur_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign dir       = dir_q;
  assign dur       = dur_q;
  assign busy      = busy_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_enemy_dir_arbiter.sv
// Directed bench for enemy_dir_arbiter: reset, latency, round-robin order, LFSR dir/dur, mid-grant reset.
module tb_enemy_dir_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] hero_x_pos = 12'd300;
  logic [11:0] hero_y_pos = 12'd120;
  logic [47:0] enemy_x_pos = {4{12'd100}};
  logic [47:0] enemy_y_pos = {4{12'd100}};
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic [2:0]  dir;
  logic [7:0]  dur;
  logic        busy;
  logic [15:0] grant_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  m_l, m_prev;
  logic [3:0]  seq_grant [5];
  logic [2:0]  seq_dir   [5];
  logic [7:0]  seq_dur   [5];
  logic [4:0]  dirs_seen;
  bit          got;

  enemy_dir_arbiter #(.N_ENEMY(4), .IDX_W(2), .SEED(8'hA5), .MIN_DUR(40)) dut (
    .clk(clk), .rst(rst), .req(req),
    .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
    .enemy_x_pos(enemy_x_pos), .enemy_y_pos(enemy_y_pos),
    .grant(grant), .grant_idx(grant_idx), .dir(dir), .dur(dur),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT sampled at the most recent edge.
  always @(posedge clk) begin
    if (!rst) m_l <= 8'hA5;
    else      m_l <= {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
    m_prev <= m_l;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [2:0] exp_dir(input logic [7:0] l);
    logic [2:0] r;
    r = l[2:0];
`ifdef ENEMY_CHASE_EN
    if (l[7:6] == 2'b11) return 3'd2;
`endif
    return (r >= 3'd5) ? r - 3'd5 : r;
  endfunction

  function automatic logic [7:0] exp_dur(input logic [7:0] l);
    logic [7:0] d;
    d = 8'd40 + {3'b000, l[7:3]};
`ifdef ENEMY_CHASE_EN
    if (l[7:6] == 2'b11) d = 8'd40;
`endif
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset held with all requests high
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_dir", 32'(dir), 32'd4);
    check("rst_dur", 32'(dur), 32'd0);
    check("rst_cnt", 32'(grant_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    rst = 1'b1;
    step();
    check("first_grant", 32'(grant), 32'h1);
    check("first_busy", 32'(busy), 32'd1);
    check("first_dir", 32'(dir), 32'(exp_dir(8'hA5)));
    check("first_dur", 32'(dur), 32'(exp_dur(8'hA5)));
    req = 4'b0000;
    step();

    // 2: single request, one-cycle grant pulse, outputs hold afterwards
    do_reset();
    req = 4'b0100;
    step();
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_idx", 32'(grant_idx), 32'd2);
    req = 4'b0000;
    step();
    check("t2_grant_off", 32'(grant), 32'h0);
    check("t2_cnt", 32'(grant_cnt), 32'd1);
    check("t2_busy_gap", 32'(busy), 32'd1);
    step();
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_idx_hold", 32'(grant_idx), 32'd2);

    // 3: all requesting, grants every third cycle in rotating order
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      seq_grant[k] = grant;
      seq_dir[k]   = dir;
      seq_dur[k]   = dur;
      check("t3_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      check("t3_dir", 32'(dir), 32'(exp_dir(m_prev)));
      check("t3_dur", 32'(dur), 32'(exp_dur(m_prev)));
      if (k < 4) begin
        step();
        check("t3_gap1", 32'(grant), 32'h0);
        step();
        check("t3_gap2", 32'(grant), 32'h0);
      end
    end
    check("t3_cnt", 32'(grant_cnt), 32'd4);

    // 4: long run against the reference LFSR
    do_reset();
    req = 4'b1111;
    dirs_seen = '0;
    for (int k = 0; k < 1000; k++) begin
      wait_grant(got);
      if (!got) break;
      check("t4_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      check("t4_dir", 32'(dir), 32'(exp_dir(m_prev)));
      check("t4_dur", 32'(dur), 32'(exp_dur(m_prev)));
      if (dir <= 3'd4) dirs_seen[dir] = 1'b1;
    end
    req = 4'b0000;
    step();
    check("t4_cnt", 32'(grant_cnt), 32'd1000);
    check("t4_dirs_seen", 32'(dirs_seen), 32'h1f);

    // 5: reset during S_GRANT, then the rotation replays identically
    do_reset();
    req = 4'b1111;
    step();
    check("t5_pre_grant", 32'(grant), 32'h1);
    rst = 1'b0;
    step();
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_cnt", 32'(grant_cnt), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_grant", 32'(grant), 32'(seq_grant[k]));
      check("t5_dir", 32'(dir), 32'(seq_dir[k]));
      check("t5_dur", 32'(dur), 32'(seq_dur[k]));
      if (k < 4) repeat (2) step();
    end
    req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
